// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: owner encoding, hold-limit default and active-low bus levels shared by the bus arbiter.
package bus_arbiter_pkg;
    localparam int BUS_OWNER_W = 2;
    typedef logic [BUS_OWNER_W-1:0] bus_owner_t;
    localparam bus_owner_t BUS_OWNER_MASTER_0 = 2'd0;
    localparam bus_owner_t BUS_OWNER_MASTER_1 = 2'd1;
    localparam bus_owner_t BUS_OWNER_MASTER_2 = 2'd2;
    localparam bus_owner_t BUS_OWNER_MASTER_3 = 2'd3;
    localparam int BUS_HOLD_LIMIT_DEFAULT = 16;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: request/grant lines between the four bus masters and the arbiter.
interface bus_arbiter_if;
    import bus_arbiter_pkg::*;
    logic m0_req_, m1_req_, m2_req_, m3_req_;
    logic s_as_;
    logic m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
    bus_owner_t owner;
    logic preempt;
    modport master (
        output m0_req_, m1_req_, m2_req_, m3_req_, s_as_,
        input  m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, owner, preempt
    );
    modport slave (
        input  m0_req_, m1_req_, m2_req_, m3_req_, s_as_,
        output m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, owner, preempt
    );
endinterface

// File: rtl/bus_rr_pick.sv
// bus_rr_pick: finds the first requester after the current owner in round-robin order.
module bus_rr_pick
    import bus_arbiter_pkg::*;
(
    input  bus_owner_t owner,
    input  logic [3:0] req_,
    output bus_owner_t next,
    output logic       others_req
);
    // Scan farthest first so the nearest requester overwrites and wins.
    always_comb begin
        next = owner;
        others_req = 1'b0;
        for (int k = 3; k >= 1; k--) begin
            if (req_[bus_owner_t'(owner + 2'(k))] == ENABLE_) begin
                next = bus_owner_t'(owner + 2'(k));
                others_req = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner of the shared four-master bus with parking and hold-limit preemption.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int HOLD_LIMIT = BUS_HOLD_LIMIT_DEFAULT
) (
    input logic         clk,
    input logic         reset_,
    bus_arbiter_if.slave bus
);
    localparam int CW = (HOLD_LIMIT == 0) ? 1 : $clog2(HOLD_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(HOLD_LIMIT);
    logic [3:0] req_;
    bus_owner_t owner_q, owner_d, next;
    logic [CW-1:0] hold_cnt, hold_d;
    logic preempt_q, others_req, own_req, release_ho, force_ho;
    assign req_ = {bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_};
    bus_rr_pick u_pick (
        .owner      (owner_q),
        .req_       (req_),
        .next       (next),
        .others_req (others_req)
    );
    // A release in the same cycle as the limit is an ordinary handover, so force requires the owner still requesting.
    always_comb begin
        own_req    = req_[owner_q] == ENABLE_;
        release_ho = !own_req && others_req;
        force_ho   = (HOLD_LIMIT != 0) && own_req && others_req && hold_cnt == LIM && bus.s_as_ == DISABLE_;
        owner_d    = (release_ho || force_ho) ? next : owner_q;
        hold_d     = (owner_d != owner_q || !others_req) ? '0 :
                     (own_req && hold_cnt != LIM) ? hold_cnt + 1'b1 : hold_cnt;
    end
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            owner_q   <= BUS_OWNER_MASTER_0;
            hold_cnt  <= '0;
            preempt_q <= 1'b0;
        end else begin
            owner_q   <= owner_d;
            hold_cnt  <= hold_d;
            preempt_q <= force_ho;
        end
    end
    assign bus.m0_grnt_ = (owner_q == BUS_OWNER_MASTER_0) ? ENABLE_ : DISABLE_;
    assign bus.m1_grnt_ = (owner_q == BUS_OWNER_MASTER_1) ? ENABLE_ : DISABLE_;
    assign bus.m2_grnt_ = (owner_q == BUS_OWNER_MASTER_2) ? ENABLE_ : DISABLE_;
    assign bus.m3_grnt_ = (owner_q == BUS_OWNER_MASTER_3) ? ENABLE_ : DISABLE_;
    assign bus.owner    = owner_q;
    assign bus.preempt  = preempt_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed checks of rotation, parking, wrap-around, preemption and async reset.
module tb_bus_arbiter;
    logic clk = 1'b0;
    logic reset_ = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    bus_arbiter_if bus ();
    bus_arbiter #(.HOLD_LIMIT(4)) dut (
        .clk    (clk),
        .reset_ (reset_),
        .bus    (bus)
    );
    always #5 clk = ~clk;
    wire [3:0] grnt = {bus.m3_grnt_, bus.m2_grnt_, bus.m1_grnt_, bus.m0_grnt_};
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic reqs(input logic [3:0] r);
        {bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_} = r;
    endtask
    initial begin
        reqs(4'b1111);
        bus.s_as_ = 1'b1;
        #12;
        check("rst_owner", 8'(bus.owner), 8'd0);
        check("rst_grnt", 8'(grnt), 8'b1110);
        check("rst_preempt", 8'(bus.preempt), 8'd0);
        reset_ = 1'b1;
        cyc(); cyc();
        check("idle_owner", 8'(bus.owner), 8'd0);
        reqs(4'b0001);
        cyc();
        check("rot_m1", 8'(grnt), 8'b1101);
        reqs(4'b0011);
        cyc();
        check("rot_m2", 8'(grnt), 8'b1011);
        reqs(4'b0111);
        cyc();
        check("rot_m3", 8'(grnt), 8'b0111);
        reqs(4'b1010);
        cyc();
        check("wrap_m0", 8'(bus.owner), 8'd0);
        reqs(4'b1011);
        cyc();
        check("to_m2", 8'(bus.owner), 8'd2);
        reqs(4'b1111);
        cyc(); cyc(); cyc();
        check("park_owner", 8'(bus.owner), 8'd2);
        check("park_grnt", 8'(grnt), 8'b1011);
        reqs(4'b1100);
        cyc();
        check("pre_own_m0", 8'(bus.owner), 8'd0);
        for (int i = 1; i <= 5; i++) begin
            bus.s_as_ = ~1'(i);
            cyc();
            check("hold_owner", 8'(bus.owner), 8'd0);
            check("hold_preempt", 8'(bus.preempt), 8'd0);
        end
        bus.s_as_ = 1'b1;
        cyc();
        check("preempt_owner", 8'(bus.owner), 8'd1);
        check("preempt_pulse", 8'(bus.preempt), 8'd1);
        bus.s_as_ = 1'b0;
        cyc();
        check("preempt_drop", 8'(bus.preempt), 8'd0);
        check("post_owner", 8'(bus.owner), 8'd1);
        reqs(4'b1110);
        cyc();
        check("regrant_m0", 8'(bus.owner), 8'd0);
        bus.s_as_ = 1'b1;
        reqs(4'b0111);
        cyc();
        check("own_m3", 8'(bus.owner), 8'd3);
        reqs(4'b0011);
        cyc(); cyc();
        check("hold_cnt_up", 8'(dut.hold_cnt), 8'd2);
        #3 reset_ = 1'b0;
        #1;
        check("async_grnt", 8'(grnt), 8'b1110);
        check("async_owner", 8'(bus.owner), 8'd0);
        check("async_hold", 8'(dut.hold_cnt), 8'd0);
        #1 reset_ = 1'b1;
        cyc();
        check("resume_m2", 8'(bus.owner), 8'd2);
        reqs(4'b0111);
        cyc();
        check("resume_m3", 8'(bus.owner), 8'd3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
